// File: rtl/tone_decoder.sv
// Square-wave period decoder: measures the tone_in period and classifies it as one
// of eight theme notes, an unrecognised tone (15) or silence (0).
module tone_decoder #(
    parameter int unsigned TOL            = 4096,
    parameter int unsigned MIN_PERIOD     = 50000,
    parameter int unsigned SILENCE_CYCLES = 1000000,
    parameter int unsigned STABLE_COUNT   = 2,
    // Divides the nominal period table by 2**PSHIFT; 0 keeps the 100 MHz table.
    parameter int unsigned PSHIFT         = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic [3:0]  note_code,
    output logic        note_valid,
    output logic [19:0] period,
    output logic        tone_active
);

    localparam logic [1:0] SILENT  = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam logic [19:0]        MIN_P  = 20'(MIN_PERIOD);
    localparam logic [19:0]        SIL_P  = 20'(SILENCE_CYCLES);
    localparam logic signed [20:0] TOL_S  = 21'(TOL);
    localparam logic [3:0]         STAB_P = 4'(STABLE_COUNT);

    function automatic logic [19:0] nominal(input logic [2:0] idx);
        case (idx)
            3'd0:    nominal = 20'(572704 >> PSHIFT);
            3'd1:    nominal = 20'(510204 >> PSHIFT);
            3'd2:    nominal = 20'(454546 >> PSHIFT);
            3'd3:    nominal = 20'(404956 >> PSHIFT);
            3'd4:    nominal = 20'(382220 >> PSHIFT);
            3'd5:    nominal = 20'(340518 >> PSHIFT);
            3'd6:    nominal = 20'(303370 >> PSHIFT);
            default: nominal = 20'(255102 >> PSHIFT);
        endcase
    endfunction

    // Scanning from the top down lets the lowest-numbered matching note win.
    function automatic logic [3:0] classify(input logic [19:0] p);
        logic signed [20:0] diff;
        logic [3:0]         code;
        code = 4'd15;
        for (int i = 7; i >= 0; i--) begin
            diff = $signed({1'b0, p}) - $signed({1'b0, nominal(3'(i))});
            if (diff <= TOL_S && diff >= -TOL_S)
                code = 4'(i + 1);
        end
        return code;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    logic        sync_p0, sync_p1, sync_p2;
    logic        edge_p3;
    logic [19:0] cnt;
    logic [1:0]  state;
    logic [3:0]  cls_p4;
    logic        vld_p4;
    logic [3:0]  cand, stab_cnt;
    logic [3:0]  next_cand, next_stab;
    logic        accept, silence;

    assign accept      = edge_p3 && (cnt >= MIN_P);
    assign silence     = !accept && (state != SILENT) && (cnt >= SIL_P);
    assign tone_active = (state != SILENT);

    always_comb begin
        next_cand = cand;
        next_stab = stab_cnt;
        if (vld_p4) begin
            if (cls_p4 != cand) begin
                next_cand = cls_p4;
                next_stab = 4'd1;
            end else begin
                next_stab = sat_inc(stab_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            sync_p2    <= 1'b0;
            edge_p3    <= 1'b0;
            cnt        <= 20'd0;
            state      <= SILENT;
            cls_p4     <= 4'd0;
            vld_p4     <= 1'b0;
            cand       <= 4'd0;
            stab_cnt   <= 4'd0;
            note_code  <= 4'd0;
            note_valid <= 1'b0;
            period     <= 20'd0;
        end else begin
            // p0..p2: synchroniser and delayed copy, p3: registered rising edge
            sync_p0 <= tone_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            edge_p3 <= sync_p1 & ~sync_p2;

            // p4: period capture and classification
            vld_p4 <= 1'b0;
            if (accept) begin
                cnt <= 20'd1;
                if (state == SILENT) begin
                    state <= ARMED;
                end else begin
                    state  <= MEASURE;
                    period <= cnt;
                    cls_p4 <= classify(cnt);
                    vld_p4 <= 1'b1;
                end
            end else begin
                if (cnt < SIL_P)
                    cnt <= cnt + 20'd1;
                if (silence)
                    state <= SILENT;
            end

            // p5: stability filter and output register
            note_valid <= 1'b0;
            if (silence) begin
                cand       <= 4'd0;
                stab_cnt   <= 4'd0;
                note_code  <= 4'd0;
                note_valid <= (note_code != 4'd0);
            end else begin
                cand     <= next_cand;
                stab_cnt <= next_stab;
                if (vld_p4 && next_stab >= STAB_P && next_cand != note_code) begin
                    note_code  <= next_cand;
                    note_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with a scaled period table: directed note vectors, silence,
// edge-versus-silence, mid-stream reset and random streams against a timestamp model.
module tb_tone_decoder;

    localparam int TOL            = 8;
    localparam int MIN_PERIOD     = 97;
    localparam int SILENCE_CYCLES = 1953;
    localparam int STABLE_COUNT   = 2;
    localparam int PSHIFT         = 9;
    localparam int NOTE_P [8] = '{572704, 510204, 454546, 404956, 382220, 340518, 303370, 255102};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tone_in;
    logic [3:0]  note_code;
    logic        note_valid;
    logic [19:0] period;
    logic        tone_active;

    always #5 clk = ~clk;

    tone_decoder #(
        .TOL(TOL), .MIN_PERIOD(MIN_PERIOD), .SILENCE_CYCLES(SILENCE_CYCLES),
        .STABLE_COUNT(STABLE_COUNT), .PSHIFT(PSHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .note_code(note_code),
        .note_valid(note_valid), .period(period), .tone_active(tone_active)
    );

    int checks = 0, passes = 0, fail_prints = 0, pulses = 0;
    int cyc = 0, last_rise = -100000;

    function automatic int nom(int i);
        return NOTE_P[i] >> PSHIFT;
    endfunction

    function automatic int ref_class(int p);
        int d;
        for (int i = 0; i < 8; i++) begin
            d = p - nom(i);
            if (d < 0) d = -d;
            if (d <= TOL) return i + 1;
        end
        return 15;
    endfunction

    // Model: tracks the time of the last accepted edge rather than a counter.
    int         m_last = 0, m_cand = 0, m_stab = 0, m_pcls = 0;
    int         q[$];
    bit         m_prev = 0, m_active = 0, m_pend = 0;
    logic [3:0] exp_note = 4'd0;
    logic       exp_valid = 1'b0;
    logic [19:0] exp_period = 20'd0;

    task automatic model_step();
        bit ev, acc, sil;
        int el;
        cyc++;
        exp_valid = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_prev = 0; m_active = 0; m_pend = 0; m_cand = 0; m_stab = 0;
            exp_note = 4'd0; exp_period = 20'd0;
            m_last = cyc + 1;
            return;
        end
        ev = (q.size() > 0) && (q[0] == cyc);
        if (ev) void'(q.pop_front());
        if (tone_in && !m_prev) q.push_back(cyc + 3);
        m_prev = tone_in;
        el = cyc - m_last;
        if (el > SILENCE_CYCLES) el = SILENCE_CYCLES;
        acc = ev && (el >= MIN_PERIOD);
        sil = !acc && m_active && (el >= SILENCE_CYCLES);
        if (sil) begin
            if (exp_note != 4'd0) exp_valid = 1'b1;
            exp_note = 4'd0; m_cand = 0; m_stab = 0; m_active = 0;
        end else if (m_pend) begin
            if (m_pcls != m_cand) begin
                m_cand = m_pcls; m_stab = 1;
            end else if (m_stab < 15) begin
                m_stab++;
            end
            if (m_stab >= STABLE_COUNT && m_cand != int'(exp_note)) begin
                exp_note = 4'(m_cand); exp_valid = 1'b1;
            end
        end
        m_pend = 0;
        if (acc) begin
            if (!m_active) begin
                m_active = 1;
            end else begin
                exp_period = 20'(el); m_pcls = ref_class(el); m_pend = 1;
            end
            m_last = cyc;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if (note_code === exp_note && note_valid === exp_valid &&
            period === exp_period && tone_active === m_active) begin
            passes++;
        end else begin
            if (fail_prints < 10)
                $display("FAIL model cyc %0d: note %0d/%0d valid %0b/%0b period %0d/%0d active %0b/%0b (got/required)",
                         cyc, note_code, exp_note, note_valid, exp_valid, period, exp_period, tone_active, m_active);
            fail_prints++;
        end
        if (note_valid) pulses++;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Each rise lands exactly p cycles after the previous one; hi cycles of high phase.
    task automatic play(input int p, input int n, input bit glitch, input int hi);
        for (int k = 0; k < n; k++) begin
            wait_until(last_rise + p);
            tone_in = 1'b1;
            last_rise = cyc;
            if (glitch) begin
                wait_until(last_rise + 40); tone_in = 1'b0;
                wait_until(last_rise + 50); tone_in = 1'b1;
            end
            wait_until(last_rise + hi);
            tone_in = 1'b0;
        end
    endtask

    typedef struct {
        string      name;
        int         per;
        int         rises;
        bit         glitch;
        logic [3:0] note;
        int         npulse;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int p0, t0, sel, p, n;
        bit g;
        tbl[0]  = '{"a3_lock",   nom(2),        3, 1'b0, 4'd3,  1};
        tbl[1]  = '{"c4_first",  nom(4),        1, 1'b0, 4'd3,  0};
        tbl[2]  = '{"c4_second", nom(4),        1, 1'b0, 4'd5,  1};
        tbl[3]  = '{"unrec",     480000 >> PSHIFT, 2, 1'b0, 4'd15, 1};
        tbl[4]  = '{"a3_again",  nom(2),        2, 1'b0, 4'd3,  1};
        tbl[5]  = '{"glitch",    nom(2),        2, 1'b1, 4'd3,  0};
        tbl[6]  = '{"g4",        nom(7),        2, 1'b0, 4'd8,  1};
        tbl[7]  = '{"f3",        nom(0),        2, 1'b0, 4'd1,  1};
        tbl[8]  = '{"e4_plus",   nom(6) + TOL,  2, 1'b0, 4'd7,  1};
        tbl[9]  = '{"e4_minus",  nom(6) - TOL,  2, 1'b0, 4'd7,  0};
        tbl[10] = '{"e4_out",    nom(6) + TOL + 1, 2, 1'b0, 4'd15, 1};

        rst_n = 1'b0;
        tone_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tone_in = ~tone_in;
        end
        check("rst note", int'(note_code), 0);
        check("rst valid", int'(note_valid), 0);
        check("rst period", int'(period), 0);
        check("rst active", int'(tone_active), 0);
        rst_n = 1'b1;
        tone_in = 1'b0;
        wait_until(cyc + 200);

        for (int i = 0; i < 11; i++) begin
            p0 = pulses;
            play(tbl[i].per, tbl[i].rises, tbl[i].glitch, tbl[i].per / 2);
            wait_until(last_rise + 8);
            check({tbl[i].name, " note"}, int'(note_code), int'(tbl[i].note));
            check({tbl[i].name, " period"}, int'(period), tbl[i].per);
            check({tbl[i].name, " active"}, int'(tone_active), 1);
            check({tbl[i].name, " pulses"}, pulses - p0, tbl[i].npulse);
        end

        play(nom(2), 2, 1'b0, nom(2) / 2);
        check("relock note", int'(note_code), 3);
        t0 = last_rise;
        wait_until(t0 + 3 + SILENCE_CYCLES);
        check("pre_silence note", int'(note_code), 3);
        check("pre_silence active", int'(tone_active), 1);
        wait_until(t0 + 4 + SILENCE_CYCLES);
        check("silence note", int'(note_code), 0);
        check("silence valid", int'(note_valid), 1);
        check("silence active", int'(tone_active), 0);
        wait_until(t0 + 5 + SILENCE_CYCLES);
        check("silence valid_drop", int'(note_valid), 0);

        p0 = pulses;
        play(nom(2), 3, 1'b0, nom(2) / 2);
        check("post_silence note", int'(note_code), 3);
        check("post_silence pulses", pulses - p0, 1);

        p0 = pulses;
        play(SILENCE_CYCLES, 1, 1'b0, 300);
        wait_until(last_rise + 8);
        check("edge_wins period", int'(period), SILENCE_CYCLES);
        check("edge_wins note", int'(note_code), 3);
        check("edge_wins active", int'(tone_active), 1);
        check("edge_wins pulses", pulses - p0, 0);

        wait_until(last_rise + nom(2));
        tone_in = 1'b1;
        last_rise = cyc;
        wait_until(last_rise + 100);
        rst_n = 1'b0;
        wait_until(last_rise + 101);
        check("midrst note", int'(note_code), 0);
        check("midrst valid", int'(note_valid), 0);
        check("midrst period", int'(period), 0);
        check("midrst active", int'(tone_active), 0);
        rst_n = 1'b1;
        wait_until(last_rise + nom(2) / 2);
        tone_in = 1'b0;
        p0 = pulses;
        play(nom(2), 2, 1'b0, nom(2) / 2);
        check("relock2 note", int'(note_code), 0);
        check("relock2 period", int'(period), nom(2));
        check("relock2 pulses", pulses - p0, 0);
        play(nom(2), 1, 1'b0, nom(2) / 2);
        check("relock3 note", int'(note_code), 3);
        check("relock3 pulses", pulses - p0, 1);

        for (int s = 0; s < 14; s++) begin
            sel = int'($urandom_range(0, 9));
            n = int'($urandom_range(1, 3));
            g = ($urandom_range(0, 3) == 0);
            if (sel < 6) begin
                p = nom(int'($urandom_range(0, 7))) + int'($urandom_range(0, 24)) - 12;
            end else if (sel < 8) begin
                p = int'($urandom_range(500, 1200));
            end else begin
                p = SILENCE_CYCLES - 3 + int'($urandom_range(0, 6));
                n = 1;
            end
            play(p, n, g, 240);
        end
        wait_until(cyc + 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Decoder counterpart to the BGM tone generator: measures the period of an incoming square-wave audio line and classifies it into one of the eight theme notes (F3, G3, A3, B3, C4, D4, E4, G4) or silence.
- Sits between a speaker-line tap / PMOD input and game logic for loopback self-test and music-sync effects.
- Runs on the 100 MHz board clock; the nominal period table is fixed to that clock.

Parameters:
- TOL, 4096, ± tolerance in clk cycles when matching a measured period to a nominal period.
- MIN_PERIOD, 50000, rising edges fewer than this many cycles after the last accepted edge are glitches and are ignored.
- SILENCE_CYCLES, 1000000, cycles without an accepted edge before the decoder declares silence.
- STABLE_COUNT, 2, consecutive identical classifications (range 1–15) required before note_code changes.

Ports:
- clk  input  1  100 MHz system clock.
- rst_n  input  1  synchronous reset, active-low.
- tone_in  input  1  asynchronous square-wave audio input.
- note_code  output  4  0 = silence; 1–8 = F3, G3, A3, B3, C4, D4, E4, G4; 15 = unrecognised tone.
- note_valid  output  1  one-cycle pulse on every change of note_code.
- period  output  20  last accepted full period, in clk cycles.
- tone_active  output  1  high while state is not SILENT.

Behaviour:
- Decided interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: note_code = 0, note_valid = 0, period = 0, tone_active = 0, FSM = SILENT, all counters and sync flops = 0.
- Reset asserted mid-operation returns every register to these values on the next clk edge. No note_valid pulse is generated by reset.
- Input path: 2-FF synchroniser, then registered rising-edge detect (edge_p).
- Period counter:
  - 20 bits; increments every cycle and saturates at SILENCE_CYCLES.
  - On an accepted edge_p it captures its value into period and restarts at 1.
- Accepted edge: edge_p with counter >= MIN_PERIOD. Glitch edges leave the counter running and have no other effect.
- Classification: match the captured period against these nominal full periods; the first match with |period − P| <= TOL wins, otherwise code 15.
  - F3 572704
  - G3 510204
  - A3 454546
  - B3 404956
  - C4 382220
  - D4 340518
  - E4 303370
  - G4 255102
- FSM states:
  - SILENT: first accepted edge → ARMED, counter restarts. That edge yields no period, so period is not updated.
  - ARMED: next accepted edge → MEASURE; period is captured and classified.
  - MEASURE: every accepted edge captures and classifies.
  - ARMED or MEASURE: counter reaching SILENCE_CYCLES → SILENT.
- Stability filter:
  - cand holds the last classification; stab_cnt counts consecutive classifications equal to cand.
  - A classification different from cand loads cand and sets stab_cnt = 1.
  - When stab_cnt >= STABLE_COUNT and cand != note_code, load note_code = cand and pulse note_valid.
- Silence: entering SILENT sets note_code = 0, pulses note_valid if note_code was nonzero, and clears cand and stab_cnt.
- Latency: note_code and note_valid update exactly 5 clk cycles after the tone_in rising transition that completes the qualifying period.
  - 2 cycles synchroniser, 1 edge detect, 1 capture/classify, 1 output register.
- Simultaneous accepted edge and counter reaching SILENCE_CYCLES: the edge wins; no silence is declared.
- note_valid is never high on two consecutive cycles.

Test Plan:
- Reset: rst_n = 0 for 4 cycles while tone_in toggles → note_code = 0, note_valid = 0, period = 0, tone_active = 0.
- A3 stream (period 454546, 50 % duty), 3 rising edges → after the 3rd edge + 5 cycles: note_code = 3, period = 454546, exactly one note_valid pulse, tone_active = 1.
- Switch the A3 stream to period 382220 → after 2 periods at the new rate: note_code = 5 (C4), one pulse; still 3 after the first new period.
- Stream at period 480000 (outside all windows) → after 2 periods: note_code = 15, one pulse.
- Glitch: during the A3 stream, 100 cycles after an edge drive tone_in low for 20 cycles then high → no pulse, next period = 454546, note_code stays 3.
- Stop toggling after A3 lock → exactly SILENCE_CYCLES after the last accepted edge: note_code = 0, one pulse, tone_active = 0.
- Reset mid-stream: assert rst_n = 0 for 1 cycle → all outputs at reset values; relock needs 3 fresh edges.
